// File: rtl/imm_instr_encoder.sv
// Packs decoded RV32 fields (format, immediate, registers, functs) into an instruction word.
// Latency: a request accepted on one edge is on the outputs after the next edge.
// Backpressure: two-stage valid/ready skid; in_ready drops only when both stages hold words.
module imm_instr_encoder #(
  parameter int              DW        = 32,
  parameter logic [DW-1:0]   BASE_ADDR = 32'h0000_0000,
  parameter logic [DW-1:0]   ADDR_STEP = DW'(4),
  parameter logic [DW-1:0]   NOP_WORD  = 32'h0000_0013
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [2:0]    imm_src,
  input  logic [DW-1:0] imm,
  input  logic [6:0]    opcode,
  input  logic [4:0]    rd,
  input  logic [4:0]    rs1,
  input  logic [4:0]    rs2,
  input  logic [2:0]    funct3,
  input  logic [6:0]    funct7,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] instr,
  output logic [DW-1:0] addr,
  output logic          err,
  output logic          err_sticky,
  output logic [15:0]   count
);

  localparam logic [2:0] SRC_I = 3'b000;
  localparam logic [2:0] SRC_B = 3'b001;
  localparam logic [2:0] SRC_S = 3'b010;
  localparam logic [2:0] SRC_U = 3'b011;
  localparam logic [2:0] SRC_R = 3'b111;

  typedef struct packed {
    logic [2:0]    src;
    logic [DW-1:0] imm;
    logic [6:0]    opcode;
    logic [4:0]    rd;
    logic [4:0]    rs1;
    logic [4:0]    rs2;
    logic [2:0]    funct3;
    logic [6:0]    funct7;
    logic          ok;
  } fields_t;

  fields_t       s1;
  logic          s1_valid;
  logic          s2_valid;
  logic          s2_free;
  logic          s1_adv;
  logic          in_xfer;
  logic          out_xfer;
  logic          hi_same;
  logic          range_ok;
  logic [DW-1:0] packed_word;

  assign s2_free   = !s2_valid || out_ready;
  assign s1_adv    = s1_valid && s2_free;
  assign in_ready  = !s1_valid || s2_free;
  assign in_xfer   = in_valid && in_ready;
  assign out_xfer  = s2_valid && out_ready;
  assign out_valid = s2_valid;

  // 12-bit signed fit: every bit from 11 upward is a copy of the sign.
  assign hi_same = (&imm[DW-1:11]) || !(|imm[DW-1:11]);

  // Classify whether the incoming immediate is representable in its format.
  always_comb begin
    range_ok = 1'b0;
    case (imm_src)
      SRC_I, SRC_B, SRC_S: range_ok = hi_same;
      SRC_U:               range_ok = (imm[11:0] == 12'd0);
      SRC_R:               range_ok = 1'b1;
      default:             range_ok = 1'b0;
    endcase
  end

  // Assemble the word from stage-1 fields; unencodable requests become a NOP.
  always_comb begin
    packed_word = NOP_WORD;
    if (s1.ok) begin
      case (s1.src)
        SRC_I: packed_word = {s1.imm[11:0], s1.rs1, s1.funct3, s1.rd, s1.opcode};
        // Branch layout: bit 10 lands in instr[7] so the extender's
        // {instr[31],instr[7],instr[30:25],instr[11:8]} reproduces imm[11:0].
        SRC_B: packed_word = {s1.imm[11], s1.imm[9:4], s1.rs2, s1.rs1, s1.funct3,
                              s1.imm[3:0], s1.imm[10], s1.opcode};
        SRC_S: packed_word = {s1.imm[11:5], s1.rs2, s1.rs1, s1.funct3,
                              s1.imm[4:0], s1.opcode};
        SRC_U: packed_word = {s1.imm[31:12], s1.rd, s1.opcode};
        SRC_R: packed_word = {s1.funct7, s1.rs2, s1.rs1, s1.funct3, s1.rd, s1.opcode};
        default: packed_word = NOP_WORD;
      endcase
    end
  end

  // Stage 1: capture request fields and the range verdict.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1       <= '0;
    end else begin
      if (in_xfer) begin
        s1_valid  <= 1'b1;
        s1.src    <= imm_src;
        s1.imm    <= imm;
        s1.opcode <= opcode;
        s1.rd     <= rd;
        s1.rs1    <= rs1;
        s1.rs2    <= rs2;
        s1.funct3 <= funct3;
        s1.funct7 <= funct7;
        s1.ok     <= range_ok;
      end else if (s1_adv) begin
        s1_valid <= 1'b0;
      end
    end
  end

  // Stage 2: hold the assembled word until downstream takes it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      instr    <= '0;
      err      <= 1'b0;
    end else begin
      if (s1_adv) begin
        s2_valid <= 1'b1;
        instr    <= packed_word;
        err      <= !s1.ok;
      end else if (out_xfer) begin
        s2_valid <= 1'b0;
      end
    end
  end

  // Address/count/sticky status; clr overrides a coincident transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr       <= BASE_ADDR;
      count      <= 16'd0;
      err_sticky <= 1'b0;
    end else if (clr) begin
      addr       <= BASE_ADDR;
      count      <= 16'd0;
      err_sticky <= 1'b0;
    end else if (out_xfer) begin
      addr       <= addr + ADDR_STEP;
      count      <= count + 16'd1;
      err_sticky <= err_sticky | err;
    end
  end

endmodule

// File: tb/tb_imm_instr_encoder.sv
module tb_imm_instr_encoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clr;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  imm_src;
  logic [31:0] imm;
  logic [6:0]  opcode;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] instr;
  logic [31:0] addr;
  logic        err;
  logic        err_sticky;
  logic [15:0] count;

  int n_cmp = 0;
  int n_err = 0;

  imm_instr_encoder dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (clr),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .imm_src    (imm_src),
    .imm        (imm),
    .opcode     (opcode),
    .rd         (rd),
    .rs1        (rs1),
    .rs2        (rs2),
    .funct3     (funct3),
    .funct7     (funct7),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .instr      (instr),
    .addr       (addr),
    .err        (err),
    .err_sticky (err_sticky),
    .count      (count)
  );

  always #5 clk = ~clk;

  // Core extender's branch-layout immediate decode.
  function automatic logic [31:0] ext_b(input logic [31:0] w);
    ext_b = {{20{w[31]}}, w[31], w[7], w[30:25], w[11:8]};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [2:0] src, input logic [31:0] i, input logic [4:0] rd_v,
                       input logic [4:0] rs1_v, input logic [4:0] rs2_v, input logic [2:0] f3,
                       input logic [6:0] f7, input logic [6:0] op);
    imm_src = src; imm = i; rd = rd_v; rs1 = rs1_v; rs2 = rs2_v;
    funct3 = f3; funct7 = f7; opcode = op;
  endtask

  // One request; on return the word sits in stage 1 and must not be visible yet.
  task automatic send(input string tag, input logic [2:0] src, input logic [31:0] i,
                      input logic [4:0] rd_v, input logic [4:0] rs1_v, input logic [4:0] rs2_v,
                      input logic [2:0] f3, input logic [6:0] f7, input logic [6:0] op);
    @(negedge clk);
    drive(src, i, rd_v, rs1_v, rs2_v, f3, f7, op);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    check({tag, "_early"}, 32'(out_valid), 32'd0);
  endtask

  // Word visible one cycle after acceptance, then transferred with out_ready=1.
  task automatic emit(input string tag, input logic [31:0] ei, input logic [31:0] ea,
                      input logic ee, input logic [15:0] ec);
    @(negedge clk);
    check({tag, "_vld"},   32'(out_valid), 32'd1);
    check({tag, "_instr"}, instr, ei);
    check({tag, "_addr"},  addr, ea);
    check({tag, "_err"},   32'(err), 32'(ee));
    @(negedge clk);
    check({tag, "_cnt"},   32'(count), 32'(ec));
    check({tag, "_gone"},  32'(out_valid), 32'd0);
  endtask

  logic [31:0] exp_b [4];
  logic [31:0] held_instr;
  logic [31:0] held_addr;
  logic        held_err;
  bit          holding;
  bit          saw_stall;
  int          tx;
  int          rx;

  initial begin
    exp_b[0] = 32'h0010_0093; exp_b[1] = 32'h0020_0113;
    exp_b[2] = 32'h0030_0193; exp_b[3] = 32'h0040_0213;
    rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    drive(3'b000, 32'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 7'd0);
    #12;
    check("rst_out_valid",  32'(out_valid), 32'd0);
    check("rst_in_ready",   32'(in_ready), 32'd1);
    check("rst_instr",      instr, 32'd0);
    check("rst_addr",       addr, 32'd0);
    check("rst_err",        32'(err), 32'd0);
    check("rst_sticky",     32'(err_sticky), 32'd0);
    check("rst_count",      32'(count), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    send("i5", 3'b000, 32'd5, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 7'h13);
    emit("i5", 32'h0050_0093, 32'd0, 1'b0, 16'd1);
    send("s8", 3'b010, 32'd8, 5'd0, 5'd3, 5'd2, 3'd2, 7'd0, 7'h23);
    emit("s8", 32'h0021_A423, 32'd4, 1'b0, 16'd2);
    send("b", 3'b001, 32'hFFFF_FFFC, 5'd0, 5'd5, 5'd6, 3'd1, 7'd0, 7'h63);
    @(negedge clk);
    check("b_instr", instr, 32'hFE62_9CE3);
    check("b_roundtrip", ext_b(instr), 32'hFFFF_FFFC);
    check("b_addr", addr, 32'd8);
    @(negedge clk);
    check("b_cnt", 32'(count), 32'd3);
    send("i2048", 3'b000, 32'd2048, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 7'h13);
    emit("i2048", 32'h0000_0013, 32'd12, 1'b1, 16'd4);
    check("sticky_set", 32'(err_sticky), 32'd1);
    send("im2048", 3'b000, 32'hFFFF_F800, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 7'h13);
    emit("im2048", 32'h8000_0013, 32'd16, 1'b0, 16'd5);
    check("sticky_held", 32'(err_sticky), 32'd1);
    send("u_ok", 3'b011, 32'h1234_5000, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 7'h37);
    emit("u_ok", 32'h1234_52B7, 32'd20, 1'b0, 16'd6);
    send("u_bad", 3'b011, 32'h1234_5001, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 7'h37);
    emit("u_bad", 32'h0000_0013, 32'd24, 1'b1, 16'd7);
    send("r_sub", 3'b111, 32'hDEAD_BEEF, 5'd3, 5'd1, 5'd2, 3'd0, 7'h20, 7'h33);
    emit("r_sub", 32'h4020_81B3, 32'd28, 1'b0, 16'd8);
    send("src100", 3'b100, 32'd0, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 7'h13);
    emit("src100", 32'h0000_0013, 32'd32, 1'b1, 16'd9);

    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    check("clr_sticky", 32'(err_sticky), 32'd0);
    check("clr_count",  32'(count), 32'd0);
    check("clr_addr",   addr, 32'd0);
    send("i2047", 3'b000, 32'd2047, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 7'h13);
    emit("i2047", 32'h7FF0_0013, 32'd0, 1'b0, 16'd1);

    // clr coincident with transfer of an err word: clr wins.
    send("clrx", 3'b000, 32'd4096, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 7'h13);
    @(negedge clk);
    check("clrx_err",  32'(err), 32'd1);
    check("clrx_addr", addr, 32'd4);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    check("clrx_count",  32'(count), 32'd0);
    check("clrx_sticky", 32'(err_sticky), 32'd0);
    check("clrx_addr0",  addr, 32'd0);
    check("clrx_gone",   32'(out_valid), 32'd0);

    // Back-to-back requests with a three-cycle output stall.
    tx = 0; rx = 0; holding = 0; saw_stall = 0;
    held_instr = '0; held_addr = '0; held_err = 1'b0;
    for (int cyc = 0; cyc < 40 && rx < 4; cyc++) begin
      @(negedge clk);
      out_ready = (cyc >= 4);
      if (tx < 4) begin
        drive(3'b000, 32'(tx + 1), 5'(tx + 1), 5'd0, 5'd0, 3'd0, 7'd0, 7'h13);
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (holding) begin
        check("hold_vld",   32'(out_valid), 32'd1);
        check("hold_instr", instr, held_instr);
        check("hold_addr",  addr, held_addr);
        check("hold_err",   32'(err), 32'(held_err));
      end
      holding    = out_valid && !out_ready;
      held_instr = instr;
      held_addr  = addr;
      held_err   = err;
      if (in_valid && !in_ready) saw_stall = 1;
      if (out_valid && out_ready) begin
        check("b2b_instr", instr, exp_b[rx]);
        check("b2b_addr",  addr, 32'(rx * 4));
        rx++;
      end
      if (in_valid && in_ready) tx++;
    end
    in_valid = 1'b0;
    check("b2b_rx",    32'(rx), 32'd4);
    check("b2b_stall", 32'(saw_stall), 32'd1);
    @(negedge clk);
    check("b2b_nodup", 32'(out_valid), 32'd0);
    check("b2b_count", 32'(count), 32'd4);

    // Asynchronous reset while a word is stalled on the output.
    out_ready = 1'b0;
    send("rstw", 3'b000, 32'd7, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 7'h13);
    @(negedge clk);
    check("rstw_vld",  32'(out_valid), 32'd1);
    check("rstw_addr", addr, 32'd16);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_vld",   32'(out_valid), 32'd0);
    check("arst_addr",  addr, 32'd0);
    check("arst_count", 32'(count), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    send("post", 3'b000, 32'd5, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 7'h13);
    emit("post", 32'h0050_0093, 32'd0, 1'b0, 16'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/imm_instr_encoder.md
Name: imm_instr_encoder

Overview:
- Streaming instruction encoder: the inverse of the core's immediate sign-extender.
- Takes decoded fields (format select, 32-bit immediate, register indices, opcode, functs) and packs them into a 32-bit RV32 instruction word.
- Feeds the instruction-memory loader and the self-test program generator.
- Two-stage valid/ready pipeline with an immediate range check, an output word-address counter and error status.

Parameters:
DW, 32, instruction/immediate/address width
BASE_ADDR, 32'h0000_0000, address tagged to first emitted word after reset/clr
ADDR_STEP, 4, address increment per emitted word
NOP_WORD, 32'h0000_0013, word substituted for an unencodable request (addi x0,x0,0)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
clr  in  1  synchronous: restart addr/count at BASE_ADDR/0, clear err_sticky
in_valid  in  1  request valid
in_ready  out  1  encoder can accept request
imm_src  in  3  format: 000 I, 001 branch-layout, 010 S, 011 U, 111 R; others invalid
imm  in  DW  sign-extended immediate value
opcode  in  7  instr[6:0]
rd  in  5  destination register
rs1  in  5  source 1
rs2  in  5  source 2
funct3  in  3  funct3
funct7  in  7  funct7 (R only)
out_valid  out  1  instr/addr/err valid
out_ready  in  1  downstream accepts
instr  out  DW  encoded instruction
addr  out  DW  word address of instr
err  out  1  this word was unencodable (instr = NOP_WORD)
err_sticky  out  1  set by any emitted err word; cleared by reset/clr
count  out  16  words emitted since reset/clr, wraps at 16'hFFFF->0

Behaviour:
- Reset (async assert, sync deassert): both stage valids 0; out_valid=0; instr=0; addr=BASE_ADDR; err=0; err_sticky=0; count=0. in_ready is 1 after reset.
- Handshake: transfer when valid&&ready on a clock edge. out_valid must not drop, and instr/addr/err must stay stable, while out_ready=0.
- in_ready = !s1_valid || (!s2_valid || out_ready) (stage1 empty or advancing). Throughput is one word/cycle; bubbles collapse.
- Stage1 registers the fields and computes range_ok:
  - I/001/S: imm[31:11] all equal (fits signed 12-bit).
  - U: imm[11:0]==0.
  - R: always ok.
  - Invalid imm_src: never ok.
- Stage2 holds the assembled word. Latency: request accepted at edge N is on outputs after edge N+1 when out_ready held 1; i.e. visible the cycle after acceptance.
- Packing (i=imm):
  - I: {i[11:0],rs1,funct3,rd,opcode}
  - 001: {i[11],i[9:4],rs2,rs1,funct3,i[3:0],i[10],opcode}. Must round-trip through the core extender's 001 decode: {instr[31],instr[7],instr[30:25],instr[11:8]} sign-extended gives back imm.
  - S: {i[11:5],rs2,rs1,funct3,i[4:0],opcode}
  - U: {i[31:12],rd,opcode}
  - R: {funct7,rs2,rs1,funct3,rd,opcode}; imm ignored.
- If !range_ok: instr=NOP_WORD, err=1, still consumes an address.
- On each output transfer:
  - addr advances by ADDR_STEP for the next word; wraps modulo 2^DW.
  - count increments.
  - err_sticky |= err.
- clr: takes effect at the edge; in-flight words are kept.
  - The first word emitted after clr carries BASE_ADDR.
  - clr coincident with an output transfer: clr wins (next addr = BASE_ADDR, count=0, err_sticky=0 even if the transferred word had err).
- Simultaneous input accept and output transfer in the same cycle is legal; no word lost or duplicated; order preserved.
- Reset mid-operation discards all in-flight words.

Test Plan:
- I-type imm=5, rs1=0, funct3=0, rd=1, opcode=7'h13, out_ready=1 -> instr=32'h0050_0093, addr=0, err=0, count=1, one cycle after acceptance.
- S-type imm=8, rs2=2, rs1=3, funct3=2, opcode=7'h23, after the I word -> instr=32'h0021_A423, addr=4.
- 001 imm=32'hFFFF_FFFC, rs2=6, rs1=5, funct3=1, opcode=7'h63 -> instr=32'hFE62_9CE3; extender ImmSrc=001 decode of it returns 32'hFFFF_FFFC.
- I-type imm=2048 -> instr=32'h0000_0013, err=1, err_sticky=1 thereafter; then clr -> err_sticky=0, next word addr=0, count restarts.
- Back-to-back 4 requests with out_ready=0 for 3 cycles -> in_ready drops once both stages full, outputs held stable. After release, words emerge in order at addr 0,4,8,12 with no loss/duplication.
- rst_n pulsed low while out_valid=1 -> out_valid=0 immediately (no clock), addr=BASE_ADDR, count=0; first post-reset word at addr 0.
